// File: rtl/arbitro_endereco_memoria.sv
// arbitro_endereco_memoria
// Round-robin arbiter and access sequencer for the memory address path.
// Four requesters (0 fetch, 1 SWR, 2 D1, 3 immediate) share one memory port.
// The granted index drives the 4:1 address mux select, and the block runs a
// request/ready handshake with the memory, aborting after a wait-state limit.
//
// Ports:
//   clock        rising-edge system clock
//   reset        synchronous, active-low reset
//   pedido[3:0]  request per source
//   escrita[3:0] write flag per source, sampled with the grant
//   mem_pronto   memory completed the current access
//   controle     address mux select, stable for the whole access
//   concedido    one-hot grant, high from grant through completion
//   concluido    one-hot, one-cycle completion pulse
//   erro_tempo   one-cycle pulse with concluido when the access timed out
//   mem_habilita memory access enable
//   mem_escrita  write strobe, only ever high with mem_habilita
//   ocupado      high whenever the sequencer is not idle
module arbitro_endereco_memoria #(
    parameter int unsigned LIMITE_ESPERA = 15,
    parameter int unsigned LARGURA_CONT  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] pedido,
    input  logic [3:0] escrita,
    input  logic       mem_pronto,
    output logic [1:0] controle,
    output logic [3:0] concedido,
    output logic [3:0] concluido,
    output logic       erro_tempo,
    output logic       mem_habilita,
    output logic       mem_escrita,
    output logic       ocupado
);

    localparam logic [LARGURA_CONT-1:0] LIMITE = LARGURA_CONT'(LIMITE_ESPERA);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENDERECO = 2'd1,
        ACESSO   = 2'd2,
        LIBERA   = 2'd3
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic [LARGURA_CONT-1:0] cont_inc;
    logic [1:0]              ultimo_q, ultimo_d;
    logic                    escrita_lat_q, escrita_lat_d;
    logic                    timeout_q, timeout_d;
    logic [1:0]              controle_q, controle_d;
    logic [3:0]              concedido_q, concedido_d;
    logic [3:0]              concluido_q, concluido_d;
    logic                    erro_tempo_q, erro_tempo_d;
    logic                    mem_habilita_q, mem_habilita_d;
    logic                    mem_escrita_q, mem_escrita_d;
    logic                    ocupado_q, ocupado_d;

    logic                    achou;
    logic [1:0]              indice;
    logic [1:0]              candidato;

    // Round-robin search: first set bit starting just after the last winner.
    always_comb begin
        achou     = 1'b0;
        indice    = ultimo_q;
        candidato = ultimo_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            candidato = ultimo_q + 2'(i);
            if (!achou && pedido[candidato]) begin
                achou  = 1'b1;
                indice = candidato;
            end
        end
    end

    assign cont_inc = cont_q + 1'b1;

    // Enable/strobe/pulse outputs are registered from the current state, so
    // they trail the state by one cycle; ocupado follows the next state.
    always_comb begin
        estado_d       = estado_q;
        cont_d         = cont_q;
        ultimo_d       = ultimo_q;
        escrita_lat_d  = escrita_lat_q;
        timeout_d      = timeout_q;
        controle_d     = controle_q;
        concedido_d    = concedido_q;
        concluido_d    = '0;
        erro_tempo_d   = 1'b0;
        mem_habilita_d = 1'b0;
        mem_escrita_d  = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (achou) begin
                    controle_d    = indice;
                    concedido_d   = 4'b0001 << indice;
                    escrita_lat_d = escrita[indice];
                    ultimo_d      = indice;
                    estado_d      = ENDERECO;
                end else begin
                    concedido_d = '0;
                end
            end
            ENDERECO: begin
                cont_d    = '0;
                timeout_d = 1'b0;
                estado_d  = ACESSO;
            end
            ACESSO: begin
                mem_habilita_d = 1'b1;
                mem_escrita_d  = escrita_lat_q;
                cont_d         = cont_inc;
                if (mem_pronto) begin
                    timeout_d = 1'b0;
                    estado_d  = LIBERA;
                end else if (cont_inc == LIMITE) begin
                    timeout_d = 1'b1;
                    estado_d  = LIBERA;
                end
            end
            LIBERA: begin
                concluido_d  = concedido_q;
                erro_tempo_d = timeout_q;
                estado_d     = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q       <= OCIOSO;
            cont_q         <= '0;
            ultimo_q       <= 2'd3;
            escrita_lat_q  <= 1'b0;
            timeout_q      <= 1'b0;
            controle_q     <= '0;
            concedido_q    <= '0;
            concluido_q    <= '0;
            erro_tempo_q   <= 1'b0;
            mem_habilita_q <= 1'b0;
            mem_escrita_q  <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cont_q         <= cont_d;
            ultimo_q       <= ultimo_d;
            escrita_lat_q  <= escrita_lat_d;
            timeout_q      <= timeout_d;
            controle_q     <= controle_d;
            concedido_q    <= concedido_d;
            concluido_q    <= concluido_d;
            erro_tempo_q   <= erro_tempo_d;
            mem_habilita_q <= mem_habilita_d;
            mem_escrita_q  <= mem_escrita_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign controle     = controle_q;
    assign concedido    = concedido_q;
    assign concluido    = concluido_q;
    assign erro_tempo   = erro_tempo_q;
    assign mem_habilita = mem_habilita_q;
    assign mem_escrita  = mem_escrita_q;
    assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_arbitro_endereco_memoria.sv
// Directed testbench for arbitro_endereco_memoria.
module tb_arbitro_endereco_memoria;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] pedido;
    logic [3:0] escrita;
    logic       mem_pronto;
    logic [1:0] controle;
    logic [3:0] concedido;
    logic [3:0] concluido;
    logic       erro_tempo;
    logic       mem_habilita;
    logic       mem_escrita;
    logic       ocupado;

    int pass_cnt  = 0;
    int total_cnt = 0;

    arbitro_endereco_memoria #(
        .LIMITE_ESPERA(15),
        .LARGURA_CONT (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pedido      (pedido),
        .escrita     (escrita),
        .mem_pronto  (mem_pronto),
        .controle    (controle),
        .concedido   (concedido),
        .concluido   (concluido),
        .erro_tempo  (erro_tempo),
        .mem_habilita(mem_habilita),
        .mem_escrita (mem_escrita),
        .ocupado     (ocupado)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b0;
        pedido     = '0;
        escrita    = '0;
        mem_pronto = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        logic [13:0] snap;
        reset      = 1'b0;
        pedido     = 4'b1111;
        escrita    = 4'b1111;
        mem_pronto = 1'b1;
        tick;
        tick;
        snap = {controle, concedido, concluido, erro_tempo, mem_habilita, mem_escrita, ocupado};
        total_cnt++;
        if (snap !== 14'b0) $display("FAIL reset_outputs got %b want 0", snap);
        else pass_cnt++;
        pedido  = '0;
        escrita = '0;
        reset   = 1'b1;
        tick;
        total_cnt++;
        if (ocupado !== 1'b0) $display("FAIL reset_idle_ocupado got %b want 0", ocupado);
        else pass_cnt++;
    endtask

    task automatic test_single;
        int mh;
        pedido     = 4'b0001;
        escrita    = '0;
        mem_pronto = 1'b1;
        mh         = 0;
        tick;
        total_cnt++;
        if (controle !== 2'b00 || concedido !== 4'b0001)
            $display("FAIL single_grant got %b/%b want 00/0001", controle, concedido);
        else pass_cnt++;
        total_cnt++;
        if (ocupado !== 1'b1 || mem_habilita !== 1'b0)
            $display("FAIL single_settle got ocupado=%b hab=%b want 1/0", ocupado, mem_habilita);
        else pass_cnt++;
        tick; if (mem_habilita) mh++;
        tick; if (mem_habilita) mh++;
        tick; if (mem_habilita) mh++;
        total_cnt++;
        if (concluido !== 4'b0001 || erro_tempo !== 1'b0)
            $display("FAIL single_concluido got %b err=%b want 0001 err=0", concluido, erro_tempo);
        else pass_cnt++;
        pedido = '0;
        tick; if (mem_habilita) mh++;
        total_cnt++;
        if (mh !== 1) $display("FAIL single_hab_cycles got %0d want 1", mh);
        else pass_cnt++;
        total_cnt++;
        if (ocupado !== 1'b0 || concluido !== 4'b0000 || concedido !== 4'b0000)
            $display("FAIL single_after got ocupado=%b conc=%b grant=%b want 0/0000/0000",
                     ocupado, concluido, concedido);
        else pass_cnt++;
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        logic [3:0] oh;
        do_reset;
        pedido     = 4'b1111;
        mem_pronto = 1'b1;
        for (int g = 0; g < 6; g++) begin
            e  = 2'(g % 4);
            oh = 4'b0001 << e;
            tick;
            total_cnt++;
            if (controle !== e || concedido !== oh)
                $display("FAIL rr_grant_%0d got %b/%b want %b/%b", g, controle, concedido, e, oh);
            else pass_cnt++;
            tick;
            tick;
            tick;
            total_cnt++;
            if (concluido !== oh)
                $display("FAIL rr_concluido_%0d got %b want %b", g, concluido, oh);
            else pass_cnt++;
        end
        pedido = '0;
        tick;
        total_cnt++;
        if (ocupado !== 1'b0) $display("FAIL rr_idle got %b want 0", ocupado);
        else pass_cnt++;
    endtask

    task automatic test_wait_states;
        int mh, me, nconc, erros;
        logic [3:0] conc;
        do_reset;
        pedido     = 4'b0100;
        escrita    = 4'b0100;
        mem_pronto = 1'b0;
        mh = 0; me = 0; nconc = 0; erros = 0; conc = '0;
        tick;
        total_cnt++;
        if (controle !== 2'b10 || concedido !== 4'b0100)
            $display("FAIL wait_grant got %b/%b want 10/0100", controle, concedido);
        else pass_cnt++;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (mem_habilita) mh++;
            if (mem_escrita) me++;
            if (erro_tempo) erros++;
            if (concluido != 4'b0000) begin
                conc    = concluido;
                nconc++;
                pedido  = '0;
                escrita = '0;
            end
            if (i == 4) mem_pronto = 1'b1;
        end
        mem_pronto = 1'b0;
        total_cnt++;
        if (mh !== 4 || me !== 4)
            $display("FAIL wait_cycles got hab=%0d wr=%0d want 4/4", mh, me);
        else pass_cnt++;
        total_cnt++;
        if (nconc !== 1 || conc !== 4'b0100 || erros !== 0)
            $display("FAIL wait_concluido got n=%0d %b err=%0d want 1 0100 0", nconc, conc, erros);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        int mh, last_mh, conc_i, nconc, erros;
        logic [3:0] conc;
        logic       erro_at;
        do_reset;
        pedido     = 4'b1000;
        mem_pronto = 1'b0;
        mh = 0; last_mh = -1; conc_i = -1; nconc = 0; erros = 0; conc = '0; erro_at = 1'b0;
        tick;
        total_cnt++;
        if (controle !== 2'b11) $display("FAIL tmo_grant got %b want 11", controle);
        else pass_cnt++;
        for (int i = 1; i <= 24; i++) begin
            tick;
            if (mem_habilita) begin
                mh++;
                last_mh = i;
            end
            if (erro_tempo) erros++;
            if (concluido != 4'b0000) begin
                conc    = concluido;
                conc_i  = i;
                erro_at = erro_tempo;
                nconc++;
                pedido  = '0;
            end
        end
        total_cnt++;
        if (mh !== 15) $display("FAIL tmo_hab_cycles got %0d want 15", mh);
        else pass_cnt++;
        total_cnt++;
        if (nconc !== 1 || conc !== 4'b1000 || erro_at !== 1'b1 || erros !== 1 || conc_i !== last_mh + 1)
            $display("FAIL tmo_pulse got n=%0d %b err=%b errs=%0d at=%0d last=%0d want 1 1000 1 1 last+1",
                     nconc, conc, erro_at, erros, conc_i, last_mh);
        else pass_cnt++;
        pedido     = 4'b0001;
        mem_pronto = 1'b1;
        tick;
        total_cnt++;
        if (controle !== 2'b00 || concedido !== 4'b0001)
            $display("FAIL tmo_next_grant got %b/%b want 00/0001", controle, concedido);
        else pass_cnt++;
        tick;
        tick;
        tick;
        total_cnt++;
        if (concluido !== 4'b0001 || erro_tempo !== 1'b0)
            $display("FAIL tmo_next_done got %b err=%b want 0001 err=0", concluido, erro_tempo);
        else pass_cnt++;
        pedido     = '0;
        mem_pronto = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        logic [13:0] snap;
        do_reset;
        pedido     = 4'b0100;
        mem_pronto = 1'b0;
        tick;
        tick;
        tick;
        total_cnt++;
        if (mem_habilita !== 1'b1) $display("FAIL rmid_in_access got %b want 1", mem_habilita);
        else pass_cnt++;
        reset = 1'b0;
        tick;
        snap = {controle, concedido, concluido, erro_tempo, mem_habilita, mem_escrita, ocupado};
        total_cnt++;
        if (snap !== 14'b0) $display("FAIL rmid_outputs got %b want 0", snap);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (concluido !== 4'b0000) $display("FAIL rmid_no_concluido got %b want 0000", concluido);
        else pass_cnt++;
        reset      = 1'b1;
        pedido     = 4'b1111;
        mem_pronto = 1'b1;
        tick;
        total_cnt++;
        if (controle !== 2'b00 || concedido !== 4'b0001)
            $display("FAIL rmid_first_grant got %b/%b want 00/0001", controle, concedido);
        else pass_cnt++;
        tick;
        tick;
        tick;
        total_cnt++;
        if (concluido !== 4'b0001) $display("FAIL rmid_done got %b want 0001", concluido);
        else pass_cnt++;
        pedido     = '0;
        mem_pronto = 1'b0;
        tick;
    endtask

    task automatic test_drop;
        int   nconc, regrant;
        logic visto;
        do_reset;
        pedido     = 4'b0010;
        mem_pronto = 1'b0;
        nconc = 0; regrant = 0; visto = 1'b0;
        tick;
        total_cnt++;
        if (controle !== 2'b01 || concedido !== 4'b0010)
            $display("FAIL drop_grant got %b/%b want 01/0010", controle, concedido);
        else pass_cnt++;
        tick;
        tick;
        pedido = '0;
        tick;
        mem_pronto = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (visto && (ocupado || concedido != 4'b0000)) regrant++;
            if (concluido == 4'b0010) begin
                nconc++;
                visto = 1'b1;
            end
        end
        mem_pronto = 1'b0;
        total_cnt++;
        if (nconc !== 1) $display("FAIL drop_concluido got %0d pulses want 1", nconc);
        else pass_cnt++;
        total_cnt++;
        if (regrant !== 0 || concedido !== 4'b0000)
            $display("FAIL drop_no_regrant got %0d cycles grant=%b want 0 0000", regrant, concedido);
        else pass_cnt++;
    endtask

    initial begin
        reset      = 1'b0;
        pedido     = '0;
        escrita    = '0;
        mem_pronto = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_wait_states;
        test_timeout;
        test_reset_mid;
        test_drop;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
